// File: rtl/nivel_monitor.sv
// Tank-level monitor: debounces a thermometer-coded sensor bus, classifies the level,
// drives a 7-segment letter and raises a latched, blinking, acknowledgeable alarm.
module nivel_monitor #(
  parameter int unsigned N_SENS        = 4,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned LOW_TH        = 1,
  parameter int unsigned HIGH_TH       = 3,
  parameter int unsigned BLINK_DIV     = 2,
  parameter logic [7:0]  SEG_ALTO      = 8'b01110111,
  parameter logic [7:0]  SEG_NORMAL    = 8'b01010100,
  parameter logic [7:0]  SEG_BAIXO     = 8'b01111100,
  parameter logic [7:0]  SEG_DESC      = 8'b01011110,
  localparam int unsigned LW           = $clog2(N_SENS + 1)
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [N_SENS-1:0] sensor,
  input  logic              ack,
  output logic [7:0]        seg,
  output logic [LW-1:0]     level,
  output logic [1:0]        state,
  output logic              alarm,
  output logic              alarm_blink
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [LW-1:0] L_LOW    = LW'(LOW_TH);
  localparam logic [LW-1:0] L_HIGH   = LW'(HIGH_TH);

  typedef enum logic [1:0] {
    StAlto   = 2'b00,
    StNormal = 2'b01,
    StBaixo  = 2'b10,
    StDesc   = 2'b11
  } state_e;

  logic [N_SENS-1:0] r_cand;
  logic [CW-1:0]     r_cnt;
  logic [N_SENS-1:0] r_acc;
  logic              r_acc_valid;
  state_e            r_state;
  logic              r_alarm;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase;

  logic              w_thermo;
  logic [LW-1:0]     w_pop;
  state_e            w_state_nxt;
  logic              w_set;
  logic              w_clr;

  // A value is a valid reading only if it is 2^k-1; k is then the level.
  always_comb begin
    w_thermo = 1'b0;
    w_pop    = '0;
    for (int k = 0; k <= N_SENS; k++) begin
      if (r_acc == N_SENS'((1 << k) - 1)) begin
        w_thermo = 1'b1;
        w_pop    = LW'(k);
      end
    end
  end

  always_comb begin
    if (!r_acc_valid) begin
      w_state_nxt = StNormal;
    end else if (!w_thermo) begin
      w_state_nxt = StDesc;
    end else if (w_pop >= L_HIGH) begin
      w_state_nxt = StAlto;
    end else if (w_pop <= L_LOW) begin
      w_state_nxt = StBaixo;
    end else begin
      w_state_nxt = StNormal;
    end
  end

  assign w_set = (w_state_nxt != StNormal);
  assign w_clr = ack && (r_state == StNormal) && (w_state_nxt == StNormal);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_cand      <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_state     <= StNormal;
      r_alarm     <= 1'b0;
      r_bcnt      <= '0;
      r_phase     <= 1'b1;
    end else begin
      if (sensor != r_cand) begin
        r_cand <= sensor;
        r_cnt  <= CW'(1);
      end else if (r_cnt == C_LAST) begin
        r_acc       <= r_cand;
        r_acc_valid <= 1'b1;
        r_cnt       <= C_STABLE;
      end else if (r_cnt < C_STABLE) begin
        r_cnt <= r_cnt + CW'(1);
      end

      r_state <= w_state_nxt;

      // Set wins over a simultaneous acknowledge.
      if (w_set) begin
        r_alarm <= 1'b1;
      end else if (w_clr) begin
        r_alarm <= 1'b0;
      end

      if (r_alarm) begin
        if (r_bcnt == B_LAST) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end else begin
        r_bcnt  <= '0;
        r_phase <= 1'b1;
      end
    end
  end

  always_comb begin
    unique case (r_state)
      StAlto:   seg = SEG_ALTO;
      StNormal: seg = SEG_NORMAL;
      StBaixo:  seg = SEG_BAIXO;
      StDesc:   seg = SEG_DESC;
    endcase
  end

  assign level       = (r_acc_valid && w_thermo) ? w_pop : '0;
  assign state       = r_state;
  assign alarm       = r_alarm;
  assign alarm_blink = r_alarm & r_phase;

endmodule
